div_unit_16: RTL and testbench
==============================

# div_unit_16

Multi-cycle 16-bit unsigned restoring divider for RISC_PROC's execute stage. It accepts a dividend/divisor pair on a start pulse and iterates one quotient bit per clock. It then presents a registered quotient and remainder with a one-cycle done pulse. Quotient and remainder feed the 16-bit 2:1 writeback select mux, whose control is driven by the decoder's divide-op flag, and the decoder stalls on busy.

## Interface
- WIDTH, 16, operand/result width; all arithmetic below is stated for 16.
- clk  input  1  rising-edge clock; the only clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- dividend  input  16  unsigned numerator; captured on accepted start.
- divisor  input  16  unsigned denominator; captured on accepted start.
- busy  output  1  high while iterating (state RUN).
- done  output  1  one-cycle pulse: results just became valid.
- quotient  output  16  registered quotient; held until next result.
- remainder  output  16  registered remainder; held until next result.
- div_by_zero  output  1  registered flag for the last result; held with results.

## Operation
- States: IDLE, RUN, DONE.
- IDLE, or DONE with start=0, goes to IDLE.
- IDLE or DONE, start=1, divisor≠0: capture operands, clear partial remainder (17 bits), load iteration count 15, go to RUN.
- IDLE or DONE, start=1, divisor=0: go to DONE directly.
  - quotient=16'hFFFF, remainder=dividend, div_by_zero=1.
- RUN, each cycle, restoring step:
  - shift {rem, q} left one bit, bringing in the next dividend MSB.
  - trial = rem − divisor at 17 bits.
  - If the trial is non-negative, rem=trial and the quotient LSB is 1. Otherwise rem is unchanged and the LSB is 0.
  - Decrement the count. The step performed at count 0 is the 16th; go to DONE.
- Entering DONE from RUN updates the quotient/remainder outputs and sets div_by_zero=0.
- The outputs change only when entering DONE. They hold through IDLE, RUN and later starts until the next result.
- start in RUN is ignored. Operands are not re-captured and the iteration is not restarted.
- done is high exactly while state is DONE, always 1 cycle.
- busy is high exactly while state is RUN.
- Results are exact unsigned: dividend = quotient·divisor + remainder, remainder < divisor.

## Timing
- Reset (rst high at an edge): state IDLE.
  - busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
  - Internal count and partial registers are cleared.
- rst has priority over start and over any in-progress RUN. Reset mid-RUN discards the operation, and no done is produced.
- Normal latency: start accepted at edge E.
  - busy is high for 16 cycles after edges E..E+15.
  - done and the new results appear after edge E+16.
- Divide-by-zero latency: done and results appear after edge E. busy never asserts.
- Back-to-back: start=1 during the DONE cycle is accepted at that edge, with no IDLE bubble. Results stay at the previous values until the next DONE.
- Outputs are all registered, with no combinational path from inputs to outputs.

## Test plan
- Basic divide: reset, then start with 100/7 at edge E. Required:
  - busy is high for 16 cycles.
  - done is high for one cycle after edge E+16, with quotient=14, remainder=2, div_by_zero=0.
  - The values hold afterwards.
- Extremes:
  - 16'hFFFF/1 gives quotient=16'hFFFF, remainder=0.
  - 5/9 gives quotient=0, remainder=5.
  - 16'hFFFF/16'hFFFF gives quotient=1, remainder=0.
- Divide by zero: 1234/0. Required:
  - busy stays 0.
  - done after edge E, with quotient=16'hFFFF, remainder=1234, div_by_zero=1.
  - A following 9/3 gives 3, 0 and clears div_by_zero.
- Start while busy: start 100/7, then pulse start with 50/5 at RUN cycle 5. Required:
  - Result is 14/2 at the original time.
  - No second done occurs.
- Back-to-back and hold: start 200/3. Hold start=1 with 81/9 during its DONE cycle. Required:
  - First done gives 66/2.
  - Outputs hold at 66/2 through the second RUN.
  - Second done appears 16 cycles later with 9/0.
- Reset mid-operation: start 1000/7, assert rst at RUN cycle 8. Required:
  - All outputs are 0 and the state is IDLE after that edge.
  - No done is produced.
  - A new start of 1000/7 completes with 142/6.

Source files
------------

// File: rtl/div_unit_16.sv
// Multi-cycle unsigned restoring divider: one quotient bit per clock, registered
// quotient/remainder/div_by_zero presented with a single-cycle done pulse.
module div_unit_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q;    // dividend bits shift out the top, quotient bits shift in
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH:0]   rem_q;
  logic [CW-1:0]    cnt_q;

  logic             idle_or_done;
  logic             accept;
  logic             zero_div;
  logic [WIDTH:0]   rem_shift;
  logic [WIDTH:0]   trial;
  logic             trial_neg;
  logic [WIDTH-1:0] q_next;
  logic [WIDTH:0]   rem_next;

  // Handshake: start is a request sampled only in IDLE/DONE; no ready is
  // exported, the decoder stalls on busy and ignores start while in RUN.
  assign idle_or_done = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept       = idle_or_done && start;
  assign zero_div     = (divisor == '0);

  // Restoring step: a borrow into the top bit marks a negative trial.
  assign rem_shift = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
  assign trial     = rem_shift - {1'b0, dvs_q};
  assign trial_neg = trial[WIDTH];
  assign q_next    = {dvd_q[WIDTH-2:0], ~trial_neg};
  assign rem_next  = trial_neg ? rem_shift : trial;

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign state_dbg = state_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) state_d = zero_div ? S_DONE : S_RUN;
        else       state_d = S_IDLE;
      end
      S_RUN: begin
        if (cnt_q == '0) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept && !zero_div) begin
        dvd_q <= dividend;
        dvs_q <= divisor;
        rem_q <= '0;
        cnt_q <= CW'(WIDTH - 1);
      end else if (accept) begin
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else if (state_q == S_RUN) begin
        dvd_q <= q_next;
        rem_q <= rem_next;
        cnt_q <= cnt_q - 1'b1;
        if (cnt_q == '0) begin
          quotient    <= q_next;
          remainder   <= rem_next[WIDTH-1:0];
          div_by_zero <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_div_unit_16.sv
// Directed-vector bench for div_unit_16: one task per scenario, inline checks.
module tb_div_unit_16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;
  logic [1:0]  state_dbg;

  int tests_run = 0;
  int tests_failed = 0;

  div_unit_16 dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: present operands with start for one edge (edge E)
  task automatic launch(input logic [15:0] a, input logic [15:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    step();
    start    = 1'b0;
  endtask

  // driver: count edges after E until done, and cycles with busy high
  task automatic wait_done(output int lat, output int busy_cyc, output bit timed_out);
    lat = 0;
    busy_cyc = 0;
    timed_out = 1'b0;
    while (!done) begin
      if (busy) busy_cyc++;
      if (lat >= 40) begin
        timed_out = 1'b1;
        break;
      end
      step();
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    tests_run++;
    if ({busy, done, div_by_zero} !== 3'b000) begin
      tests_failed++;
      $display("FAIL reset_flags: got busy/done/dbz=%b, want 000", {busy, done, div_by_zero});
    end
    tests_run++;
    if ({quotient, remainder} !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_results: got q=%h r=%h, want 0/0", quotient, remainder);
    end
    tests_run++;
    if (state_dbg !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_state: got %0d, want 0", state_dbg);
    end
  endtask

  task automatic test_basic();
    int lat, bc;
    bit to;
    launch(16'd100, 16'd7);
    wait_done(lat, bc, to);
    tests_run++;
    if (to !== 1'b0 || lat !== 16) begin
      tests_failed++;
      $display("FAIL basic_latency: got %0d (timeout=%0d), want 16", lat, to);
    end
    tests_run++;
    if (bc !== 16) begin
      tests_failed++;
      $display("FAIL basic_busy_cycles: got %0d, want 16", bc);
    end
    tests_run++;
    if ({quotient, remainder, div_by_zero} !== {16'd14, 16'd2, 1'b0}) begin
      tests_failed++;
      $display("FAIL basic_result: got q=%0d r=%0d dbz=%b, want 14/2/0", quotient, remainder, div_by_zero);
    end
    step();
    tests_run++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL basic_done_pulse: got done=%b busy=%b, want 0/0", done, busy);
    end
    step();
    step();
    tests_run++;
    if ({quotient, remainder} !== {16'd14, 16'd2}) begin
      tests_failed++;
      $display("FAIL basic_hold: got q=%0d r=%0d, want 14/2", quotient, remainder);
    end
  endtask

  task automatic test_extremes();
    logic [15:0] va [3] = '{16'hFFFF, 16'd5, 16'hFFFF};
    logic [15:0] vb [3] = '{16'd1, 16'd9, 16'hFFFF};
    logic [15:0] eq [3] = '{16'hFFFF, 16'd0, 16'd1};
    logic [15:0] er [3] = '{16'd0, 16'd5, 16'd0};
    int lat, bc;
    bit to;
    for (int i = 0; i < 3; i++) begin
      launch(va[i], vb[i]);
      wait_done(lat, bc, to);
      tests_run++;
      if (to || {quotient, remainder, div_by_zero} !== {eq[i], er[i], 1'b0}) begin
        tests_failed++;
        $display("FAIL extreme_%0d: %h/%h got q=%h r=%h dbz=%b to=%0d, want q=%h r=%h dbz=0",
                 i, va[i], vb[i], quotient, remainder, div_by_zero, to, eq[i], er[i]);
      end
    end
    step();
  endtask

  task automatic test_div_zero();
    int lat, bc;
    bit to;
    launch(16'd1234, 16'd0);
    wait_done(lat, bc, to);
    tests_run++;
    if (to || lat !== 0 || bc !== 0) begin
      tests_failed++;
      $display("FAIL dz_latency: got lat=%0d busy_cycles=%0d, want 0/0", lat, bc);
    end
    tests_run++;
    if ({quotient, remainder, div_by_zero} !== {16'hFFFF, 16'd1234, 1'b1}) begin
      tests_failed++;
      $display("FAIL dz_result: got q=%h r=%0d dbz=%b, want ffff/1234/1", quotient, remainder, div_by_zero);
    end
    step();
    launch(16'd9, 16'd3);
    tests_run++;
    if (div_by_zero !== 1'b1) begin
      tests_failed++;
      $display("FAIL dz_hold_in_run: got dbz=%b, want 1", div_by_zero);
    end
    wait_done(lat, bc, to);
    tests_run++;
    if (to || lat !== 16 || {quotient, remainder, div_by_zero} !== {16'd3, 16'd0, 1'b0}) begin
      tests_failed++;
      $display("FAIL dz_followup: got lat=%0d q=%0d r=%0d dbz=%b, want 16/3/0/0", lat, quotient, remainder, div_by_zero);
    end
    step();
  endtask

  task automatic test_start_busy();
    int lat, bc, extra;
    bit to;
    launch(16'd100, 16'd7);
    for (int i = 0; i < 5; i++) step();
    dividend = 16'd50;
    divisor  = 16'd5;
    start    = 1'b1;
    step();
    start    = 1'b0;
    wait_done(lat, bc, to);
    tests_run++;
    if (to || lat + 6 !== 16) begin
      tests_failed++;
      $display("FAIL busy_start_latency: got %0d, want 16", lat + 6);
    end
    tests_run++;
    if ({quotient, remainder} !== {16'd14, 16'd2}) begin
      tests_failed++;
      $display("FAIL busy_start_result: got q=%0d r=%0d, want 14/2", quotient, remainder);
    end
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) extra++;
    end
    tests_run++;
    if (extra !== 0) begin
      tests_failed++;
      $display("FAIL busy_start_second_done: got %0d extra done cycles, want 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, bad_hold;
    bit to;
    launch(16'd200, 16'd3);
    wait_done(lat, bc, to);
    tests_run++;
    if (to || {quotient, remainder} !== {16'd66, 16'd2}) begin
      tests_failed++;
      $display("FAIL b2b_first: got q=%0d r=%0d, want 66/2", quotient, remainder);
    end
    launch(16'd81, 16'd9);
    tests_run++;
    if (busy !== 1'b1) begin
      tests_failed++;
      $display("FAIL b2b_no_bubble: got busy=%b, want 1", busy);
    end
    bad_hold = 0;
    lat = 0;
    to = 1'b0;
    while (!done) begin
      if ({quotient, remainder} !== {16'd66, 16'd2}) bad_hold++;
      if (lat >= 40) begin
        to = 1'b1;
        break;
      end
      step();
      lat++;
    end
    tests_run++;
    if (bad_hold !== 0) begin
      tests_failed++;
      $display("FAIL b2b_hold: got %0d cycles off 66/2, want 0", bad_hold);
    end
    tests_run++;
    if (to || lat !== 16 || {quotient, remainder} !== {16'd9, 16'd0}) begin
      tests_failed++;
      $display("FAIL b2b_second: got lat=%0d q=%0d r=%0d, want 16/9/0", lat, quotient, remainder);
    end
    step();
  endtask

  task automatic test_reset_mid();
    int lat, bc, dones;
    bit to;
    launch(16'd1000, 16'd7);
    for (int i = 0; i < 7; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests_run++;
    if ({busy, done, div_by_zero, quotient, remainder, state_dbg} !== 37'h0) begin
      tests_failed++;
      $display("FAIL midreset_clear: got busy=%b done=%b dbz=%b q=%h r=%h st=%0d, want all 0",
               busy, done, div_by_zero, quotient, remainder, state_dbg);
    end
    dones = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (done) dones++;
    end
    tests_run++;
    if (dones !== 0) begin
      tests_failed++;
      $display("FAIL midreset_no_done: got %0d done cycles, want 0", dones);
    end
    launch(16'd1000, 16'd7);
    wait_done(lat, bc, to);
    tests_run++;
    if (to || lat !== 16 || {quotient, remainder} !== {16'd142, 16'd6}) begin
      tests_failed++;
      $display("FAIL midreset_restart: got lat=%0d q=%0d r=%0d, want 16/142/6", lat, quotient, remainder);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_div_zero();
    test_start_busy();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
